// File: rtl/pre_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : pre_scheduler
//  Purpose  : Per-bank precharge scheduler. Latches PRE requests from the
//             bank FSMs, holds each until that bank's tRAS counter reaches 0,
//             round-robin arbitrates among eligible banks and offers one PRE
//             at a time to the command-slot mux over a valid/ready handshake.
//  Ports    : i_clk          - clock, rising edge
//             i_rstn         - synchronous active-low reset
//             i_ras_counter  - packed per-bank tRAS counters, bank bt at
//                              [bt*TIME_WIDTH +: TIME_WIDTH], bt = {rnk,bg,bnk}
//             i_pre_req      - one-cycle precharge request pulse per bank
//             i_pre_cancel   - drop the pending request per bank
//             i_pre_ready    - command slot accepts the offered PRE
//             o_pre_valid    - PRE offered
//             o_cmd_type     - PRE while offering, NOP otherwise
//             o_cmd_rnk/bg/bnk - address of the offered PRE (ACT encoding)
//             o_pending      - registered pending-request vector
//  Revision : 1.0  initial release
// ============================================================================

`ifndef NOP
`define NOP 3'b111
`endif
`ifndef PRE
`define PRE 3'b010
`endif

module pre_scheduler #(
    parameter int  CMD_TYPE_WIDTH = 3,
    parameter int  NUM_RNK        = 1,
    parameter int  NUM_BG         = 2,
    parameter int  NUM_BNK        = 4,
    parameter int  RNK_SEL_WIDTH  = 1,
    parameter int  BG_SEL_WIDTH   = 2 - 1,
    parameter int  BNK_SEL_WIDTH  = 2,
    parameter int  TIME_WIDTH     = 6,
    // Clock-to-q delay used by behavioural siblings; synthesizable registers
    // here carry no delay, the parameter is kept so instantiations match.
    parameter real TCQ            = 0.1
) (
    input  logic                                          i_clk,
    input  logic                                          i_rstn,
    input  logic [NUM_RNK*NUM_BG*NUM_BNK*TIME_WIDTH-1:0]  i_ras_counter,
    input  logic [NUM_RNK*NUM_BG*NUM_BNK-1:0]             i_pre_req,
    input  logic [NUM_RNK*NUM_BG*NUM_BNK-1:0]             i_pre_cancel,
    input  logic                                          i_pre_ready,
    output logic                                          o_pre_valid,
    output logic [CMD_TYPE_WIDTH-1:0]                     o_cmd_type,
    output logic [RNK_SEL_WIDTH-1:0]                      o_cmd_rnk,
    output logic [BG_SEL_WIDTH-1:0]                       o_cmd_bg,
    output logic [BNK_SEL_WIDTH-1:0]                      o_cmd_bnk,
    output logic [NUM_RNK*NUM_BG*NUM_BNK-1:0]             o_pending
);

    localparam int NUM_BNK_TOT = NUM_RNK * NUM_BG * NUM_BNK;
    localparam int PTR_W       = (NUM_BNK_TOT > 1) ? $clog2(NUM_BNK_TOT) : 1;
    localparam int FIELD_W     = RNK_SEL_WIDTH + BG_SEL_WIDTH + BNK_SEL_WIDTH;

    localparam logic [CMD_TYPE_WIDTH-1:0] C_CMD_PRE = CMD_TYPE_WIDTH'(`PRE);
    localparam logic [CMD_TYPE_WIDTH-1:0] C_CMD_NOP = CMD_TYPE_WIDTH'(`NOP);
    localparam logic [PTR_W-1:0]          C_LAST    = PTR_W'(NUM_BNK_TOT - 1);
    localparam logic [NUM_BNK_TOT-1:0]    C_ONE     = {{(NUM_BNK_TOT-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    state_t                     state_q;
    logic [NUM_BNK_TOT-1:0]     pending_q;
    logic [NUM_BNK_TOT-1:0]     pending_d;
    logic [PTR_W-1:0]           rr_ptr_q;
    logic [PTR_W-1:0]           idx_q;
    logic                       valid_q;
    logic [CMD_TYPE_WIDTH-1:0]  cmd_type_q;
    logic [RNK_SEL_WIDTH-1:0]   rnk_q;
    logic [BG_SEL_WIDTH-1:0]    bg_q;
    logic [BNK_SEL_WIDTH-1:0]   bnk_q;

    logic [NUM_BNK_TOT-1:0]     w_elig;
    logic [NUM_BNK_TOT-1:0]     w_clr;
    logic                       w_accept;
    logic                       w_found;
    logic [PTR_W-1:0]           w_winner;
    int                         w_idx;

    // A bank may be precharged only once its tRAS window has fully elapsed.
    for (genvar b = 0; b < NUM_BNK_TOT; b++) begin : g_elig
        assign w_elig[b] = pending_q[b] &
                           (i_ras_counter[b*TIME_WIDTH +: TIME_WIDTH] == '0);
    end

    // valid_q is only high in OFFER, so this is the handshake completing.
    assign w_accept  = valid_q & i_pre_ready;
    assign w_clr     = i_pre_cancel | (w_accept ? (C_ONE << idx_q) : '0);
    // Request is OR-ed last so a new pulse survives a same-cycle clear.
    assign pending_d = (pending_q & ~w_clr) | i_pre_req;

    // Round-robin search: start at rr_ptr, ascend, wrap modulo NUM_BNK_TOT.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        for (int k = 0; k < NUM_BNK_TOT; k++) begin
            w_idx = int'(rr_ptr_q) + k;
            if (w_idx >= NUM_BNK_TOT) begin
                w_idx = w_idx - NUM_BNK_TOT;
            end
            if (!w_found && w_elig[w_idx[PTR_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[PTR_W-1:0];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            rr_ptr_q   <= '0;
            idx_q      <= '0;
            valid_q    <= 1'b0;
            cmd_type_q <= C_CMD_NOP;
            rnk_q      <= '0;
            bg_q       <= '0;
            bnk_q      <= '0;
        end else begin
            pending_q <= pending_d;
            case (state_q)
                ST_IDLE: begin
                    if (w_found) begin
                        idx_q                 <= w_winner;
                        valid_q               <= 1'b1;
                        cmd_type_q            <= C_CMD_PRE;
                        {rnk_q, bg_q, bnk_q}  <= FIELD_W'(w_winner);
                        state_q               <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    // Accept takes priority over a simultaneous cancel: the
                    // slot has already consumed the PRE. tRAS is not rechecked.
                    if (i_pre_ready) begin
                        valid_q    <= 1'b0;
                        cmd_type_q <= C_CMD_NOP;
                        rr_ptr_q   <= (idx_q == C_LAST) ? '0 : idx_q + 1'b1;
                        state_q    <= ST_IDLE;
                    end else if (i_pre_cancel[idx_q]) begin
                        valid_q    <= 1'b0;
                        cmd_type_q <= C_CMD_NOP;
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_pre_valid = valid_q;
    assign o_cmd_type  = cmd_type_q;
    assign o_cmd_rnk   = rnk_q;
    assign o_cmd_bg    = bg_q;
    assign o_cmd_bnk   = bnk_q;
    assign o_pending   = pending_q;

endmodule

`default_nettype wire

// File: tb/tb_pre_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pre_scheduler
//  Purpose  : Directed self-checking bench for pre_scheduler (default params,
//             8 banks). Inputs change and outputs are sampled 1 time unit
//             after each rising edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pre_scheduler;

    localparam logic [2:0] C_PRE = 3'b010;
    localparam logic [2:0] C_NOP = 3'b111;

    logic        clk = 1'b0;
    logic        rstn;
    logic [5:0]  ras [8];
    logic [47:0] ras_flat;
    logic [7:0]  pre_req;
    logic [7:0]  pre_cancel;
    logic        pre_ready;
    logic        pre_valid;
    logic [2:0]  cmd_type;
    logic [0:0]  cmd_rnk;
    logic [0:0]  cmd_bg;
    logic [1:0]  cmd_bnk;
    logic [7:0]  pending;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    always_comb begin
        ras_flat = '0;
        for (int b = 0; b < 8; b++) begin
            ras_flat[b*6 +: 6] = ras[b];
        end
    end

    pre_scheduler dut (
        .i_clk         (clk),
        .i_rstn        (rstn),
        .i_ras_counter (ras_flat),
        .i_pre_req     (pre_req),
        .i_pre_cancel  (pre_cancel),
        .i_pre_ready   (pre_ready),
        .o_pre_valid   (pre_valid),
        .o_cmd_type    (cmd_type),
        .o_cmd_rnk     (cmd_rnk),
        .o_cmd_bg      (cmd_bg),
        .o_cmd_bnk     (cmd_bnk),
        .o_pending     (pending)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_offer(input string tag, input int bank);
        check({tag, "_valid"}, 32'(pre_valid), 32'd1);
        check({tag, "_cmd"},   32'(cmd_type),  32'(C_PRE));
        check({tag, "_idx"},   32'({cmd_rnk, cmd_bg, cmd_bnk}), 32'(bank));
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_valid"}, 32'(pre_valid), 32'd0);
        check({tag, "_cmd"},   32'(cmd_type),  32'(C_NOP));
    endtask

    // Drive a one-cycle request pulse on the given bank mask.
    task automatic pulse_req(input logic [7:0] mask);
        pre_req = mask;
        tick();
        pre_req = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rstn       = 1'b0;
        pre_req    = '0;
        pre_cancel = '0;
        pre_ready  = 1'b0;
        for (int b = 0; b < 8; b++) ras[b] = '0;

        // ---------------- reset state ----------------
        tick();
        tick();
        expect_idle("reset");
        check("reset_pending", 32'(pending), 32'h0);
        check("reset_fields", 32'({cmd_rnk, cmd_bg, cmd_bnk}), 32'h0);
        rstn = 1'b1;

        // ---------------- counter wait (bank 5) ----------------
        ras[5] = 6'd8;
        pulse_req(8'h20);
        check("cw_pending", 32'(pending), 32'h20);
        expect_idle("cw_ras8");
        ras[5] = 6'd4;
        tick();
        expect_idle("cw_ras4");
        ras[5] = 6'd0;
        tick();
        expect_offer("cw_offer", 5);
        check("cw_rnk", 32'(cmd_rnk), 32'd0);
        check("cw_bg",  32'(cmd_bg),  32'd1);
        check("cw_bnk", 32'(cmd_bnk), 32'd1);
        pre_ready = 1'b1;
        tick();
        pre_ready = 1'b0;
        expect_idle("cw_done");
        check("cw_pending_clr", 32'(pending), 32'h0);

        // ---------------- round robin ----------------
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        pulse_req(8'h4A);                 // banks 1, 3, 6
        pre_ready = 1'b1;
        tick(); expect_offer("rr_g1", 1);
        tick(); expect_idle("rr_b1");
        tick(); expect_offer("rr_g3", 3);
        tick(); expect_idle("rr_b3");
        tick(); expect_offer("rr_g6", 6);
        tick(); expect_idle("rr_b6");
        check("rr_pending_empty", 32'(pending), 32'h0);
        pre_ready = 1'b0;
        pulse_req(8'h42);                 // banks 1, 6 with rr_ptr = 7
        tick(); expect_offer("rr_wrap_g1", 1);
        pre_ready = 1'b1;
        tick(); expect_idle("rr_wrap_b");
        tick(); expect_offer("rr_wrap_g6", 6);
        tick(); expect_idle("rr_wrap_end");
        pre_ready = 1'b0;

        // ---------------- backpressure (bank 2) ----------------
        pulse_req(8'h04);
        tick(); expect_offer("bp_offer", 2);
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_offer("bp_hold", 2);
            check("bp_pending_hold", 32'(pending), 32'h04);
        end
        pre_ready = 1'b1;
        tick();
        pre_ready = 1'b0;
        expect_idle("bp_done");
        check("bp_pending_clr", 32'(pending), 32'h0);

        // ---------------- cancel (bank 4) ----------------
        pulse_req(8'h10);
        tick(); expect_offer("cn_offer", 4);
        pre_cancel = 8'h10;
        tick();
        pre_cancel = '0;
        expect_idle("cn_withdraw");
        check("cn_pending_clr", 32'(pending), 32'h0);
        tick(); expect_idle("cn_stays_idle");
        // cancel together with ready: issued, so rr_ptr moves to 5
        pulse_req(8'h10);
        tick(); expect_offer("cn2_offer", 4);
        pre_cancel = 8'h10;
        pre_ready  = 1'b1;
        tick();
        pre_cancel = '0;
        pre_ready  = 1'b0;
        expect_idle("cn2_issued");
        check("cn2_pending_clr", 32'(pending), 32'h0);
        pulse_req(8'h28);                 // banks 3, 5: 5 wins iff PRE issued
        tick(); expect_offer("cn2_rr_g5", 5);
        pre_ready = 1'b1;
        tick(); expect_idle("cn2_rr_b");
        tick(); expect_offer("cn2_rr_g3", 3);
        tick(); expect_idle("cn2_rr_end");
        pre_ready = 1'b0;

        // ---------------- request / accept collision (bank 3) ----------------
        pulse_req(8'h08);
        tick(); expect_offer("col_offer", 3);
        pre_ready = 1'b1;
        pre_req   = 8'h08;
        tick();
        pre_ready = 1'b0;
        pre_req   = '0;
        expect_idle("col_bubble");
        check("col_pending_kept", 32'(pending), 32'h08);
        tick(); expect_offer("col_reoffer", 3);
        pre_ready = 1'b1;
        tick();
        pre_ready = 1'b0;
        check("col_pending_clr", 32'(pending), 32'h0);

        // ---------------- reset mid-offer ----------------
        pulse_req(8'h81);                 // banks 0, 7 with rr_ptr = 4
        tick(); expect_offer("rst_offer", 7);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        expect_idle("rst_mid");
        check("rst_pending", 32'(pending), 32'h0);
        tick(); expect_idle("rst_no_reoffer");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
